// File: rtl/bank_sram_write_sequencer_pkg.sv
// Local types for the bank SRAM write sequencer.
package bank_sram_write_sequencer_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;
endpackage

// File: rtl/tau_cfg_pkg.sv
// Shared Tau configuration constants used across the butterfly datapath.
package TauCfg;
  localparam int XOR_BW = 4;
endpackage

// File: rtl/bank_sram_write_sequencer_skid.sv
// Two-entry FIFO between the upstream beat stream and the butterfly write port.
// Full is a pure register so the upstream busy never depends on downstream busy.
module BankSramWriteSkid #(
  parameter int W = 128
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  output logic         o_full,
  input  logic [W-1:0] i_data,
  output logic         o_dval,
  input  logic         i_pop_busy,
  output logic [W-1:0] o_data
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   cnt_q;
  logic         push;
  logic         pop;

  assign push   = i_push && (cnt_q != 2'd2);
  assign pop    = (cnt_q != 2'd0) && !i_pop_busy;
  assign o_full = (cnt_q == 2'd2);
  assign o_dval = (cnt_q != 2'd0);
  assign o_data = head_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b11: begin
          // Occupancy holds; the head advances and the new beat takes the freed slot.
          if (cnt_q == 2'd1) begin
            head_q <= i_data;
          end else begin
            head_q <= tail_q;
            tail_q <= i_data;
          end
        end
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= i_data;
          else               tail_q <= i_data;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bank_sram_write_sequencer.sv
// Sequences a configured number of beats into the butterfly write stage,
// generating the wrapping row address and carrying the xor configuration.
module bank_sram_write_sequencer
  import bank_sram_write_sequencer_pkg::*;
#(
  parameter int BW      = 8,
  parameter int NBANK   = 16,
  parameter int NDATA   = 32,
  parameter int XOR_BW  = TauCfg::XOR_BW,
  parameter int CNT_BW  = 16,
  localparam int HA_BW   = $clog2(NDATA),
  localparam int SEL_BW  = $clog2(NBANK),
  localparam int SWAP_BW = ($clog2(SEL_BW) > 0) ? $clog2(SEL_BW) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cfg_dval,
  output logic                     o_cfg_busy,
  input  logic [HA_BW-1:0]         i_cfg_base,
  input  logic [CNT_BW-1:0]        i_cfg_nbeat,
  input  logic [XOR_BW*SEL_BW-1:0] i_cfg_xor_src,
  input  logic [SWAP_BW-1:0]       i_cfg_xor_swap,
  input  logic                     i_dval,
  output logic                     o_busy,
  input  logic [BW*NBANK-1:0]      i_data,
  output logic                     o_dval,
  input  logic                     i_busy,
  output logic [BW*NBANK-1:0]      o_data,
  output logic [HA_BW-1:0]         o_hiaddr,
  output logic [XOR_BW*SEL_BW-1:0] o_xor_src,
  output logic [SWAP_BW-1:0]       o_xor_swap,
  output logic                     o_last,
  output logic                     o_done
);

  seq_state_e                 state_q;
  logic [CNT_BW-1:0]          nbeat_q;
  logic [XOR_BW*SEL_BW-1:0]   xor_src_q;
  logic [SWAP_BW-1:0]         xor_swap_q;
  logic [HA_BW-1:0]           hiaddr_q;
  logic [CNT_BW-1:0]          in_cnt_q;
  logic [CNT_BW-1:0]          out_cnt_q;
  logic                       zero_done_q;

  logic fifo_full;
  logic fifo_dval;
  logic busy;
  logic cfg_hs;
  logic in_hs;
  logic pop;
  logic last;

  assign busy   = fifo_full || (state_q != RUN) || (in_cnt_q == nbeat_q);
  assign cfg_hs = i_cfg_dval && (state_q == IDLE);
  assign in_hs  = i_dval && !busy;
  assign pop    = fifo_dval && !i_busy;
  assign last   = fifo_dval && (out_cnt_q == nbeat_q - CNT_BW'(1));

  assign o_busy     = busy;
  assign o_cfg_busy = (state_q == RUN);
  assign o_dval     = fifo_dval;
  assign o_hiaddr   = hiaddr_q;
  assign o_xor_src  = xor_src_q;
  assign o_xor_swap = xor_swap_q;
  assign o_last     = last;
  // Completion must coincide with the final write handshake, so it cannot be registered.
  assign o_done     = (pop && last) || zero_done_q;

  BankSramWriteSkid #(
    .W(BW*NBANK)
  ) u_skid (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (in_hs),
    .o_full     (fifo_full),
    .i_data     (i_data),
    .o_dval     (fifo_dval),
    .i_pop_busy (i_busy),
    .o_data     (o_data)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      nbeat_q     <= '0;
      xor_src_q   <= '0;
      xor_swap_q  <= '0;
      hiaddr_q    <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_hs) begin
            nbeat_q    <= i_cfg_nbeat;
            xor_src_q  <= i_cfg_xor_src;
            xor_swap_q <= i_cfg_xor_swap;
            hiaddr_q   <= i_cfg_base;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            if (i_cfg_nbeat != '0) state_q     <= RUN;
            else                   zero_done_q <= 1'b1;
          end
        end
        RUN: begin
          if (in_hs) in_cnt_q <= in_cnt_q + CNT_BW'(1);
          if (pop) begin
            out_cnt_q <= out_cnt_q + CNT_BW'(1);
            hiaddr_q  <= (hiaddr_q == HA_BW'(NDATA - 1)) ? '0 : hiaddr_q + HA_BW'(1);
            if (last) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bank_sram_write_sequencer.sv
// Scoreboard bench for bank_sram_write_sequencer: expected beats are queued on
// input acceptance and compared when the write stage takes them.
module tb_bank_sram_write_sequencer;
  localparam int BW      = 8;
  localparam int NBANK   = 16;
  localparam int NDATA   = 32;
  localparam int XOR_BW  = 4;
  localparam int CNT_BW  = 16;
  localparam int HA_BW   = 5;
  localparam int SEL_BW  = 4;
  localparam int SWAP_BW = 2;
  localparam int DW      = BW*NBANK;
  localparam int XW      = XOR_BW*SEL_BW;

  logic               i_clk;
  logic               i_rst;
  logic               i_cfg_dval;
  logic               o_cfg_busy;
  logic [HA_BW-1:0]   i_cfg_base;
  logic [CNT_BW-1:0]  i_cfg_nbeat;
  logic [XW-1:0]      i_cfg_xor_src;
  logic [SWAP_BW-1:0] i_cfg_xor_swap;
  logic               i_dval;
  logic               o_busy;
  logic [DW-1:0]      i_data;
  logic               o_dval;
  logic               i_busy;
  logic [DW-1:0]      o_data;
  logic [HA_BW-1:0]   o_hiaddr;
  logic [XW-1:0]      o_xor_src;
  logic [SWAP_BW-1:0] o_xor_swap;
  logic               o_last;
  logic               o_done;

  bank_sram_write_sequencer #(
    .BW(BW), .NBANK(NBANK), .NDATA(NDATA), .XOR_BW(XOR_BW), .CNT_BW(CNT_BW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cfg_dval(i_cfg_dval), .o_cfg_busy(o_cfg_busy),
    .i_cfg_base(i_cfg_base), .i_cfg_nbeat(i_cfg_nbeat),
    .i_cfg_xor_src(i_cfg_xor_src), .i_cfg_xor_swap(i_cfg_xor_swap),
    .i_dval(i_dval), .o_busy(o_busy), .i_data(i_data),
    .o_dval(o_dval), .i_busy(i_busy), .o_data(o_data),
    .o_hiaddr(o_hiaddr), .o_xor_src(o_xor_src), .o_xor_swap(o_xor_swap),
    .o_last(o_last), .o_done(o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [DW-1:0]    data;
    logic [HA_BW-1:0] hiaddr;
    logic             last;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_in   = 0;
  int   n_out  = 0;

  // Bench model of the latched job configuration.
  logic [HA_BW-1:0]   m_base;
  logic [CNT_BW-1:0]  m_nbeat;
  logic [XW-1:0]      m_xsrc;
  logic [SWAP_BW-1:0] m_xswap;
  int                 m_idx;
  logic               pend_zero;
  logic               hold_vld;
  logic [DW-1:0]      hold_data;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  always @(negedge i_clk) begin
    logic exp_done;
    exp_t e;
    if (!i_rst) begin
      sb.delete();
      pend_zero = 1'b0;
      hold_vld  = 1'b0;
      m_idx     = 0;
    end else begin
      exp_done  = pend_zero;
      pend_zero = 1'b0;
      if (o_dval && !i_busy) begin
        n_out++;
        if (sb.size() == 0) begin
          check_eq("unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check_eq("out_data", o_data, e.data);
          check_eq("out_hiaddr", DW'(o_hiaddr), DW'(e.hiaddr));
          check_eq("out_last", DW'(o_last), DW'(e.last));
          check_eq("out_xor_src", DW'(o_xor_src), DW'(m_xsrc));
          check_eq("out_xor_swap", DW'(o_xor_swap), DW'(m_xswap));
          exp_done = exp_done | e.last;
        end
      end
      if (o_done || exp_done) check_eq("done", DW'(o_done), DW'(exp_done));
      if (hold_vld) begin
        check_eq("hold_dval", DW'(o_dval), 1);
        check_eq("hold_data", o_data, hold_data);
      end
      hold_vld  = o_dval && i_busy;
      hold_data = o_data;
      if (i_dval && !o_busy) begin
        e.data   = i_data;
        e.hiaddr = HA_BW'((int'(m_base) + m_idx) % NDATA);
        e.last   = (m_idx == int'(m_nbeat) - 1);
        sb.push_back(e);
        m_idx++;
        n_in++;
      end
      if (i_cfg_dval && !o_cfg_busy) begin
        m_base  = i_cfg_base;
        m_nbeat = i_cfg_nbeat;
        m_xsrc  = i_cfg_xor_src;
        m_xswap = i_cfg_xor_swap;
        m_idx   = 0;
        if (i_cfg_nbeat == '0) pend_zero = 1'b1;
      end
    end
  end

  task automatic do_cfg(input int base, input int nbeat, input logic [XW-1:0] xs, input logic [SWAP_BW-1:0] xw);
    i_cfg_base     = HA_BW'(base);
    i_cfg_nbeat    = CNT_BW'(nbeat);
    i_cfg_xor_src  = xs;
    i_cfg_xor_swap = xw;
    i_cfg_dval     = 1'b1;
    @(posedge i_clk); #1;
    i_cfg_dval     = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    logic acc;
    acc    = 1'b0;
    i_dval = 1'b1;
    i_data = d;
    for (int t = 0; t < 64 && !acc; t++) begin
      @(negedge i_clk);
      acc = !o_busy;
      @(posedge i_clk); #1;
    end
    i_dval = 1'b0;
    if (!acc) check_eq("send_timeout", 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    logic idle;
    idle = 1'b0;
    for (int t = 0; t < 100 && !idle; t++) begin
      @(negedge i_clk);
      idle = !o_cfg_busy && !o_dval && (sb.size() == 0);
    end
    check_eq({tag, "_idle"}, DW'(idle), 1);
  endtask

  function automatic logic [DW-1:0] rnd_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_in;
    i_rst = 1'b0; i_cfg_dval = 1'b0; i_cfg_base = '0; i_cfg_nbeat = '0;
    i_cfg_xor_src = '0; i_cfg_xor_swap = '0; i_dval = 1'b0; i_data = '0; i_busy = 1'b0;
    m_base = '0; m_nbeat = '0; m_xsrc = '0; m_xswap = '0; m_idx = 0;
    pend_zero = 1'b0; hold_vld = 1'b0; hold_data = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_eq("rst_dval", DW'(o_dval), 0);
    check_eq("rst_done", DW'(o_done), 0);
    check_eq("rst_last", DW'(o_last), 0);
    check_eq("rst_busy", DW'(o_busy), 1);
    check_eq("rst_cfg_busy", DW'(o_cfg_busy), 0);
    check_eq("rst_hiaddr", DW'(o_hiaddr), 0);
    check_eq("rst_data", o_data, 0);
    check_eq("rst_xor_src", DW'(o_xor_src), 0);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;

    // Address wrap across NDATA with free-flowing output.
    do_cfg(30, 4, 16'hA5C3, 2'd2);
    @(negedge i_clk);
    check_eq("run_cfg_busy", DW'(o_cfg_busy), 1);
    @(posedge i_clk); #1;
    for (int i = 0; i < 4; i++) send_beat(rnd_beat());
    wait_idle("wrap");
    check_eq("wrap_nout", DW'(n_out), 4);

    // Zero-length job completes immediately.
    do_cfg(7, 0, 16'h1234, 2'd1);
    repeat (4) begin
      @(negedge i_clk);
      check_eq("zero_dval", DW'(o_dval), 0);
    end
    check_eq("zero_cfg_busy", DW'(o_cfg_busy), 0);
    @(posedge i_clk); #1;

    // Downstream stall fills the FIFO.
    do_cfg(3, 3, 16'h0F0F, 2'd3);
    i_busy = 1'b1;
    fork
      begin
        repeat (5) @(posedge i_clk);
        #1 i_busy = 1'b0;
      end
      begin
        send_beat(rnd_beat());
        send_beat(rnd_beat());
        @(negedge i_clk);
        check_eq("stall_busy_full", DW'(o_busy), 1);
        @(posedge i_clk); #1;
        send_beat(rnd_beat());
      end
    join
    wait_idle("stall");
    check_eq("stall_nout", DW'(n_out), 7);

    // Extra beat beyond nbeat is refused.
    do_cfg(12, 4, 16'h3C3C, 2'd0);
    base_in = n_in;
    for (int i = 0; i < 4; i++) send_beat(rnd_beat());
    i_dval = 1'b1;
    i_data = rnd_beat();
    repeat (3) begin
      @(negedge i_clk);
      check_eq("extra_busy", DW'(o_busy), 1);
      @(posedge i_clk); #1;
    end
    i_dval = 1'b0;
    wait_idle("extra");
    check_eq("extra_accepted", DW'(n_in - base_in), 4);

    // Reset in the middle of a job.
    do_cfg(5, 4, 16'h7777, 2'd1);
    i_busy = 1'b1;
    send_beat(rnd_beat());
    send_beat(rnd_beat());
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    i_rst  = 1'b1;
    i_busy = 1'b0;
    @(negedge i_clk);
    check_eq("abort_dval", DW'(o_dval), 0);
    check_eq("abort_done", DW'(o_done), 0);
    check_eq("abort_cfg_busy", DW'(o_cfg_busy), 0);
    check_eq("abort_busy", DW'(o_busy), 1);
    check_eq("abort_xor_src", DW'(o_xor_src), 0);
    @(posedge i_clk); #1;
    do_cfg(5, 4, 16'h8421, 2'd2);
    for (int i = 0; i < 4; i++) send_beat(rnd_beat());
    wait_idle("after_rst");

    // Config attempt while running is ignored.
    do_cfg(20, 2, 16'hBEEF, 2'd3);
    i_cfg_base = 5'd1; i_cfg_nbeat = 16'd9; i_cfg_xor_src = 16'h1111; i_cfg_xor_swap = 2'd0;
    i_cfg_dval = 1'b1;
    repeat (2) begin
      @(negedge i_clk);
      check_eq("run_cfg_blocked", DW'(o_cfg_busy), 1);
      check_eq("run_xor_src", DW'(o_xor_src), DW'(16'hBEEF));
      check_eq("run_xor_swap", DW'(o_xor_swap), 3);
      @(posedge i_clk); #1;
    end
    i_cfg_dval = 1'b0;
    for (int i = 0; i < 2; i++) send_beat(rnd_beat());
    wait_idle("cfg_run");

    repeat (2) @(posedge i_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
